// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed seven-segment scanner. Display inputs are captured once
// per frame so a mid-frame update never tears the visible number.
module seg_scan_driver #(
   parameter int SCAN_DIV = 1000,
   parameter int DEAD     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [31:0] data,
   input  logic [7:0]  dp_mask,
   input  logic [7:0]  blank_mask,
   input  logic        lz_en,
   output logic [7:0]  segO,
   output logic [7:0]  sig,
   output logic        frame_tick
);
   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [CW-1:0] cnt;
   logic [2:0]    digit;
   logic          loadPend;
   logic [31:0]   snapData;
   logic [7:0]    snapDp;
   logic [7:0]    snapBlank;
   logic          snapLz;
   logic          slotEnd;
   logic          loadNow;
   logic [7:0]    supp;
   logic [3:0]    nib;
   logic [7:0]    curSeg;

   function automatic logic [6:0] hexSeg(input logic [3:0] n);
      case (n)
         4'h0: hexSeg = 7'h3F;
         4'h1: hexSeg = 7'h06;
         4'h2: hexSeg = 7'h5B;
         4'h3: hexSeg = 7'h4F;
         4'h4: hexSeg = 7'h66;
         4'h5: hexSeg = 7'h6D;
         4'h6: hexSeg = 7'h7D;
         4'h7: hexSeg = 7'h07;
         4'h8: hexSeg = 7'h7F;
         4'h9: hexSeg = 7'h6F;
         4'hA: hexSeg = 7'h77;
         4'hB: hexSeg = 7'h7C;
         4'hC: hexSeg = 7'h39;
         4'hD: hexSeg = 7'h5E;
         4'hE: hexSeg = 7'h79;
         default: hexSeg = 7'h71;
      endcase
   endfunction

   assign slotEnd = (cnt == CW'(SCAN_DIV - 1));
   assign loadNow = en && (loadPend || (slotEnd && (digit == 3'd7)));

   // A digit is suppressed when it and every digit to its left are zero; digit 0 never is.
   always_comb begin
      logic zeroAbove;
      zeroAbove = 1'b1;
      supp      = '0;
      for (int k = 7; k >= 1; k--) begin
         zeroAbove = zeroAbove && (snapData[4*k +: 4] == 4'h0);
         supp[k]   = snapLz && zeroAbove;
      end
   end

   always_comb begin
      nib = snapData[{digit, 2'b00} +: 4];
      if (snapBlank[digit])
         curSeg = 8'h00;
      else if (supp[digit])
         curSeg = {snapDp[digit], 7'h00};
      else
         curSeg = {snapDp[digit], hexSeg(nib)};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         digit      <= '0;
         loadPend   <= 1'b1;
         snapData   <= '0;
         snapDp     <= '0;
         snapBlank  <= '0;
         snapLz     <= 1'b0;
         frame_tick <= 1'b0;
         sig        <= 8'hFF;
         segO       <= 8'h00;
      end else if (!en) begin
         cnt        <= '0;
         digit      <= '0;
         loadPend   <= 1'b1;
         frame_tick <= 1'b0;
         sig        <= 8'hFF;
         segO       <= 8'h00;
      end else begin
         cnt        <= slotEnd ? '0 : cnt + 1'b1;
         if (slotEnd)
            digit <= digit + 3'd1;
         frame_tick <= loadNow;
         if (loadNow) begin
            snapData  <= data;
            snapDp    <= dp_mask;
            snapBlank <= blank_mask;
            snapLz    <= lz_en;
            loadPend  <= 1'b0;
         end
         // Blanking at the start of each slot lets the previous digit's driver turn off.
         if (cnt < CW'(DEAD)) begin
            sig  <= 8'hFF;
            segO <= 8'h00;
         end else begin
            sig  <= ~(8'b1 << digit);
            segO <= curSeg;
         end
      end
   end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: a time-indexed frame model checked every cycle,
// plus hand-decoded per-digit expectations for each directed scenario.
module tb_seg_scan_driver;
   localparam int SD    = 4;
   localparam int DT    = 1;
   localparam int FRAME = 8 * SD;
   localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic        clk = 1'b0;
   logic        rst, en, lz_en;
   logic [31:0] data;
   logic [7:0]  dp_mask, blank_mask;
   logic [7:0]  segO, sig;
   logic        frame_tick;

   int nChecks = 0;
   int nFail   = 0;

   seg_scan_driver #(.SCAN_DIV(SD), .DEAD(DT)) dut (
      .clk(clk), .rst(rst), .en(en), .data(data), .dp_mask(dp_mask),
      .blank_mask(blank_mask), .lz_en(lz_en), .segO(segO), .sig(sig),
      .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   // Model: position within the frame is just the count of enabled cycles since restart.
   int          mT = 0;
   logic [31:0] mData  = '0;
   logic [7:0]  mDp    = '0;
   logic [7:0]  mBlank = '0;
   logic        mLz    = 1'b0;
   logic [7:0]  expSeg, expSig;
   logic        expTick;
   logic        expValid = 1'b0;

   function automatic logic [7:0] modelSeg(input int d);
      logic [31:0] sh;
      sh = mData >> (4 * d);
      if (mBlank[d])
         return 8'h00;
      if (mLz && d > 0 && sh == 32'h0)
         return {mDp[d], 7'h00};
      return {mDp[d], HEX[sh[3:0]]};
   endfunction

   always @(posedge clk) begin
      int  p, d, off;
      logic load;
      if (rst) begin
         mT = 0; mData = '0; mDp = '0; mBlank = '0; mLz = 1'b0;
         expSeg = 8'h00; expSig = 8'hFF; expTick = 1'b0;
      end else if (!en) begin
         mT = 0;
         expSeg = 8'h00; expSig = 8'hFF; expTick = 1'b0;
      end else begin
         p   = mT % FRAME;
         d   = p / SD;
         off = p % SD;
         if (off < DT) begin
            expSeg = 8'h00; expSig = 8'hFF;
         end else begin
            expSig = ~(8'h01 << d);
            expSeg = modelSeg(d);
         end
         load = (mT == 0) || (p == FRAME - 1);
         if (load) begin
            mData = data; mDp = dp_mask; mBlank = blank_mask; mLz = lz_en;
         end
         expTick = load;
         mT++;
      end
      expValid = 1'b1;
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
      if (expValid) begin
         check("model_segO", segO, expSeg);
         check("model_sig", sig, expSig);
         check("model_tick", {7'b0, frame_tick}, {7'b0, expTick});
      end
   endtask

   task automatic waitTick(input int budget);
      int i;
      i = 0;
      do begin
         step();
         i++;
      end while (!frame_tick && i < budget);
      check("tick_wait", {7'b0, frame_tick}, 8'h01);
   endtask

   task automatic stepFrame();
      for (int k = 0; k < FRAME; k++) step();
   endtask

   // Starts on a wrap frame_tick cycle; records the first lit segment value of each digit.
   task automatic collectFrame(input logic [63:0] exp, input logic [7:0] changeSig,
                               input logic [31:0] newData);
      logic [7:0] rec [8];
      logic [7:0] seen;
      logic       changed;
      seen    = '0;
      changed = 1'b0;
      for (int d = 0; d < 8; d++) rec[d] = 8'hEE;
      for (int k = 0; k < FRAME; k++) begin
         step();
         if (!changed && changeSig != 8'h00 && sig == changeSig) begin
            data    = newData;
            changed = 1'b1;
         end
         for (int d = 0; d < 8; d++)
            if (sig == ~(8'h01 << d) && !seen[d]) begin
               rec[d]  = segO;
               seen[d] = 1'b1;
            end
      end
      for (int d = 0; d < 8; d++)
         check($sformatf("digit%0d_seg", d), rec[d], exp[8*d +: 8]);
      check("tick_period", {7'b0, frame_tick}, 8'h01);
   endtask

   initial begin
      logic [39:0] sigSeq;
      rst = 1'b1; en = 1'b0; lz_en = 1'b0;
      data = 32'h89ABCDEF; dp_mask = 8'h00; blank_mask = 8'h00;
      repeat (3) step();
      check("reset_sig", sig, 8'hFF);
      check("reset_seg", segO, 8'h00);
      check("reset_tick", {7'b0, frame_tick}, 8'h00);

      rst = 1'b0; en = 1'b1;
      waitTick(8);
      step();
      check("first_lit_sig", sig, 8'hFE);
      check("first_tick_once", {7'b0, frame_tick}, 8'h00);

      waitTick(2 * FRAME);
      collectFrame({8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71}, 8'h00, '0);

      // Data cleared while digit 3 is lit: the rest of this frame keeps the old snapshot.
      collectFrame({8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71}, 8'hF7, 32'h0);
      collectFrame({8{8'h3F}}, 8'h00, '0);

      data = 32'h00000120; lz_en = 1'b1; dp_mask = 8'h02;
      stepFrame();
      collectFrame({8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h06, 8'hDB, 8'h3F}, 8'h00, '0);
      data = 32'h0;
      stepFrame();
      collectFrame({8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h3F}, 8'h00, '0);

      data = 32'h12345678; lz_en = 1'b0; dp_mask = 8'h00; blank_mask = 8'h81;
      stepFrame();
      collectFrame({8'h00, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h00}, 8'h00, '0);

      repeat (10) step();
      en = 1'b0;
      step();
      check("en_off_sig", sig, 8'hFF);
      check("en_off_seg", segO, 8'h00);
      check("en_off_tick", {7'b0, frame_tick}, 8'h00);
      repeat (3) step();
      en = 1'b1;
      repeat (6) step();
      rst = 1'b1;
      step();
      check("rst_mid_sig", sig, 8'hFF);
      check("rst_mid_seg", segO, 8'h00);
      rst = 1'b0;
      waitTick(8);
      sigSeq = {8'hFD, 8'hFF, 8'hFE, 8'hFE, 8'hFE};
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("restart_sig%0d", k), sig, sigSeq[8*k +: 8]);
      end
      repeat (FRAME) step();

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end
endmodule
